// File: rtl/hazard3_debug_entry_ctrl_pkg.sv
// Shared definitions for the Hazard3 debug entry controller: dcsr.cause
// codes, the controller state encoding and a small state helper.
package hazard3_debug_entry_ctrl_pkg;

  // Width of the dcsr.cause codes used internally
  localparam int CAUSE_W = 3;

  typedef logic [CAUSE_W-1:0] cause_t;

  // dcsr.cause encodings
  localparam cause_t CAUSE_NONE      = 3'd0;
  localparam cause_t CAUSE_EBREAK    = 3'd1;
  localparam cause_t CAUSE_TRIGGER   = 3'd2;
  localparam cause_t CAUSE_HALTREQ   = 3'd3;
  localparam cause_t CAUSE_STEP      = 3'd4;
  localparam cause_t CAUSE_RESETHALT = 3'd5;

  // Controller states
  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_ENTRY_PEND  = 3'd1,
    ST_HALTED      = 3'd2,
    ST_RESUME_PEND = 3'd3,
    ST_STEP        = 3'd4
  } dbg_state_e;

  // True in the states where the core executes instructions normally and
  // new halt causes are accepted.
  function automatic logic state_accepts_causes(dbg_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/hazard3_debug_entry_ctrl_if.sv
// Bundle of the controller's core / trigger unit / Debug Module signals.
// master: the debug entry controller. slave: the surrounding core and DM.
interface hazard3_debug_entry_ctrl_if #(
  parameter int CAUSE_W = 3
) ();

  // Towards the controller
  logic               x_valid;
  logic               trig_break_any;
  logic               trig_break_d_mode;
  logic               x_ebreak_dmode;
  logic               dbg_haltreq;
  logic               dbg_resumereq;
  logic               dcsr_step;
  logic               instr_retire;
  logic               core_entry_ack;
  logic               core_resume_ack;

  // From the controller
  logic               m_break_trap;
  logic               entry_req;
  logic [CAUSE_W-1:0] entry_cause;
  logic               d_mode;
  logic               resume_req;
  logic               dbg_halted;
  logic               dbg_resumeack;

  modport master (
    input  x_valid, trig_break_any, trig_break_d_mode, x_ebreak_dmode,
           dbg_haltreq, dbg_resumereq, dcsr_step, instr_retire,
           core_entry_ack, core_resume_ack,
    output m_break_trap, entry_req, entry_cause, d_mode, resume_req,
           dbg_halted, dbg_resumeack
  );

  modport slave (
    output x_valid, trig_break_any, trig_break_d_mode, x_ebreak_dmode,
           dbg_haltreq, dbg_resumereq, dcsr_step, instr_retire,
           core_entry_ack, core_resume_ack,
    input  m_break_trap, entry_req, entry_cause, d_mode, resume_req,
           dbg_halted, dbg_resumeack
  );

endinterface

// File: rtl/hazard3_debug_cause_arb.sv
// Fixed-priority encoder from qualified halt requests to a single dcsr.cause.
// Priority: reset-halt, trigger, ebreak, haltreq, step.
module hazard3_debug_cause_arb
  import hazard3_debug_entry_ctrl_pkg::*;
(
  input  logic   req_resethalt_i,
  input  logic   req_trigger_i,
  input  logic   req_ebreak_i,
  input  logic   req_haltreq_i,
  input  logic   req_step_i,
  output logic   valid_o,
  output cause_t cause_o
);

  // Pick the highest-priority active request
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves
    // it unassigned; a missing default here would infer a latch.
    valid_o = 1'b0;
    cause_o = CAUSE_NONE;
    if (req_resethalt_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_RESETHALT;
    end else if (req_trigger_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_TRIGGER;
    end else if (req_ebreak_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_EBREAK;
    end else if (req_haltreq_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_HALTREQ;
    end else if (req_step_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_STEP;
    end
  end

endmodule

// File: rtl/hazard3_debug_entry_ctrl.sv
// Hazard3 Debug Mode entry/exit sequencer.
// Collects halt causes (D-mode trigger, ebreak, DM haltreq, single-step),
// requests entry from the core, tracks Debug Mode, and sequences resume.
// Also raises M-mode breakpoint traps for action=0 trigger matches.
// Optional build macro HAZARD3_RESET_HALT_EN adds dbg_resethaltreq, which
// halts the core (cause 5) on the first cycle after reset.
module hazard3_debug_entry_ctrl
  import hazard3_debug_entry_ctrl_pkg::*;
#(
  parameter int RESET_CAUSE_W = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef HAZARD3_RESET_HALT_EN
  input  logic                           dbg_resethaltreq,
`endif
  hazard3_debug_entry_ctrl_if.master     ctrl_bus
);

  dbg_state_e               state_q;
  logic                     entry_req_q;
  logic [RESET_CAUSE_W-1:0] entry_cause_q;
  logic                     d_mode_q;
  logic                     resume_req_q;
  logic                     dbg_halted_q;
  logic                     resumeack_q;
  logic                     step_armed_q;   // dcsr.step captured at resumereq

  logic   accepting;
  logic   req_resethalt;
  logic   req_trigger;
  logic   req_ebreak;
  logic   req_haltreq;
  logic   req_step;
  logic   cause_valid;
  cause_t cause_sel;

  assign accepting = state_accepts_causes(state_q);

  // Trigger and ebreak belong to the X-stage instruction, so they only count
  // when that instruction is really there. haltreq can halt an empty pipe.
  assign req_trigger = accepting & ctrl_bus.x_valid & ctrl_bus.trig_break_any
                     & ctrl_bus.trig_break_d_mode;
  assign req_ebreak  = accepting & ctrl_bus.x_valid & ctrl_bus.x_ebreak_dmode;
  assign req_haltreq = accepting & ctrl_bus.dbg_haltreq;
  assign req_step    = (state_q == ST_STEP) & ctrl_bus.instr_retire;

`ifdef HAZARD3_RESET_HALT_EN
  // The request level cannot be clocked in while reset is held, so a flag set
  // by reset marks the first cycle afterwards, where the level is sampled.
  logic resethalt_arm_q;

  // Arm on reset, disarm after the first clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resethalt_arm_q <= 1'b1;
    end else begin
      resethalt_arm_q <= 1'b0;
    end
  end

  assign req_resethalt = accepting & resethalt_arm_q & dbg_resethaltreq;
`else
  assign req_resethalt = 1'b0;
`endif

  hazard3_debug_cause_arb u_cause_arb (
    .req_resethalt_i (req_resethalt),
    .req_trigger_i   (req_trigger),
    .req_ebreak_i    (req_ebreak),
    .req_haltreq_i   (req_haltreq),
    .req_step_i      (req_step),
    .valid_o         (cause_valid),
    .cause_o         (cause_sel)
  );

  // Main FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    if (!rst_n) begin
      state_q       <= ST_RUN;
      entry_req_q   <= 1'b0;
      entry_cause_q <= '0;
      d_mode_q      <= 1'b0;
      resume_req_q  <= 1'b0;
      dbg_halted_q  <= 1'b0;
      resumeack_q   <= 1'b0;
      step_armed_q  <= 1'b0;
    end else begin
      resumeack_q <= 1'b0;
      unique case (state_q)
        ST_RUN, ST_STEP: begin
          if (cause_valid) begin
            state_q       <= ST_ENTRY_PEND;
            entry_req_q   <= 1'b1;
            entry_cause_q <= RESET_CAUSE_W'(cause_sel);
          end
        end
        // Causes are ignored here, so entry_cause stays put until the core
        // has saved it.
        ST_ENTRY_PEND: begin
          if (ctrl_bus.core_entry_ack) begin
            state_q      <= ST_HALTED;
            entry_req_q  <= 1'b0;
            d_mode_q     <= 1'b1;
            dbg_halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (ctrl_bus.dbg_resumereq) begin
            state_q      <= ST_RESUME_PEND;
            resume_req_q <= 1'b1;
            step_armed_q <= ctrl_bus.dcsr_step;
          end
        end
        ST_RESUME_PEND: begin
          if (ctrl_bus.core_resume_ack) begin
            state_q      <= step_armed_q ? ST_STEP : ST_RUN;
            resume_req_q <= 1'b0;
            d_mode_q     <= 1'b0;
            dbg_halted_q <= 1'b0;
            resumeack_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // An action=0 trigger traps to M-mode only when nothing is taking the core
  // into Debug Mode this cycle.
  assign ctrl_bus.m_break_trap  = accepting & ctrl_bus.x_valid
                                & ctrl_bus.trig_break_any
                                & ~ctrl_bus.trig_break_d_mode & ~cause_valid;

  assign ctrl_bus.entry_req     = entry_req_q;
  assign ctrl_bus.entry_cause   = entry_cause_q;
  assign ctrl_bus.d_mode        = d_mode_q;
  assign ctrl_bus.resume_req    = resume_req_q;
  assign ctrl_bus.dbg_halted    = dbg_halted_q;
  assign ctrl_bus.dbg_resumeack = resumeack_q;

endmodule
